// File: rtl/polygon_sequencer_pkg.sv
// Shared types and constants for the polygon sequencer: FSM states, viewport
// half-extents and the per-polygon table stride.
package polygon_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH_HDR,
        FETCH_VERTS,
        START,
        WAIT_DONE,
        NEXT,
        FRAME_DONE
    } state_t;

    localparam int HALF_W = 640;
    localparam int HALF_H = 360;

    // Each polygon block is one header entry followed by its vertex slots.
    function automatic int tbl_stride(input int max_vertices);
        return max_vertices + 1;
    endfunction

endpackage

// File: rtl/polygon_sequencer_if.sv
// Polygon table read bus: registered address out, signed x/y data back after
// a fixed read latency.
interface polygon_sequencer_if #(
    parameter int MAX_NUM_VERTICES = 4,
    parameter int MAX_POLYGONS     = 16
);
    localparam int AW = $clog2(MAX_POLYGONS * (MAX_NUM_VERTICES + 1));

    logic [AW-1:0]      tbl_addr_out;
    logic signed [31:0] tbl_x_in;
    logic signed [31:0] tbl_y_in;

    modport master (output tbl_addr_out, input tbl_x_in, input tbl_y_in);
    modport slave  (input tbl_addr_out, output tbl_x_in, output tbl_y_in);
endinterface

// File: rtl/polygon_sequencer_bbox_cull.sv
// Bounding-box versus viewport overlap test; only present when
// POLYGON_SEQ_CULL_EN is defined.
`ifdef POLYGON_SEQ_CULL_EN
module bbox_cull
    import polygon_sequencer_pkg::*;
#(
    parameter int NV = 4
)(
    input  logic signed [31:0]   xs [NV],
    input  logic signed [31:0]   ys [NV],
    input  logic [$clog2(NV):0]  num_points,
    input  logic signed [31:0]   cam_x,
    input  logic signed [31:0]   cam_y,
    output logic                 visible
);
    // Widened so camera +/- half-extent never wraps.
    logic signed [33:0] min_x, max_x, min_y, max_y;
    logic signed [33:0] vx_lo, vx_hi, vy_lo, vy_hi;

    always_comb begin
        min_x = 34'(xs[0]);
        max_x = 34'(xs[0]);
        min_y = 34'(ys[0]);
        max_y = 34'(ys[0]);
        for (int i = 1; i < NV; i++) begin
            if (i < int'(num_points)) begin
                if (34'(xs[i]) < min_x) min_x = 34'(xs[i]);
                if (34'(xs[i]) > max_x) max_x = 34'(xs[i]);
                if (34'(ys[i]) < min_y) min_y = 34'(ys[i]);
                if (34'(ys[i]) > max_y) max_y = 34'(ys[i]);
            end
        end
        vx_lo   = 34'(cam_x) - 34'(HALF_W);
        vx_hi   = 34'(cam_x) + 34'(HALF_W - 1);
        vy_lo   = 34'(cam_y) - 34'(HALF_H);
        vy_hi   = 34'(cam_y) + 34'(HALF_H - 1);
        visible = (max_x >= vx_lo) && (min_x <= vx_hi) &&
                  (max_y >= vy_lo) && (min_y <= vy_hi);
    end
endmodule
`endif

// File: rtl/polygon_sequencer.sv
// Walks the polygon table once per frame and hands each valid polygon to the
// rasteriser. Optional viewport culling: define POLYGON_SEQ_CULL_EN.
//
// state       | meaning
// IDLE        | waiting for frame_start_in
// FETCH_HDR   | header address issued, waiting out the read latency
// FETCH_VERTS | vertex addresses streamed, vertices captured as data returns
// START       | (cull check) then launch the rasteriser
// WAIT_DONE   | waiting for draw_done_in
// NEXT        | advance polygon index, loop or finish
// FRAME_DONE  | frame_done_out pulse
module polygon_sequencer
    import polygon_sequencer_pkg::*;
#(
    parameter int MAX_NUM_VERTICES = 4,
    parameter int MAX_POLYGONS     = 16,
    parameter int TBL_LATENCY      = 2
)(
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          frame_start_in,
    input  logic [$clog2(MAX_POLYGONS):0] num_polygons_in,
    input  logic signed [31:0]            camera_x_in,
    input  logic signed [31:0]            camera_y_in,
    polygon_sequencer_if.master           tbl,
    output logic                          draw_start_out,
    output logic signed [31:0]            xs_out [MAX_NUM_VERTICES],
    output logic signed [31:0]            ys_out [MAX_NUM_VERTICES],
    output logic [$clog2(MAX_NUM_VERTICES):0] num_points_out,
    output logic signed [31:0]            camera_x_out,
    output logic signed [31:0]            camera_y_out,
    input  logic                          draw_done_in,
    output logic                          busy_out,
    output logic                          frame_done_out,
    output logic [$clog2(MAX_POLYGONS):0] skipped_out
);
    localparam int PW  = $clog2(MAX_POLYGONS) + 1;
    localparam int CW  = $clog2(MAX_NUM_VERTICES) + 1;
    localparam int IW  = $clog2(MAX_NUM_VERTICES);
    localparam int AW  = $clog2(MAX_POLYGONS * (MAX_NUM_VERTICES + 1));
    localparam int WCW = $clog2(TBL_LATENCY + 1) + 1;
    localparam logic [AW-1:0] STRIDE = AW'(tbl_stride(MAX_NUM_VERTICES));

    state_t           state;
    logic [PW-1:0]    npoly;
    logic [PW-1:0]    poly_idx;
    logic [AW-1:0]    base;
    logic [CW-1:0]    iss;
    logic [IW-1:0]    cap_idx;
    logic [WCW-1:0]   wcnt;
    logic [TBL_LATENCY:0] vpipe;
    logic [CW-1:0]    hdr_cnt;
    logic             visible;

    assign hdr_cnt = tbl.tbl_x_in[CW-1:0];

`ifdef POLYGON_SEQ_CULL_EN
    bbox_cull #(.NV(MAX_NUM_VERTICES)) u_cull (
        .xs         (xs_out),
        .ys         (ys_out),
        .num_points (num_points_out),
        .cam_x      (camera_x_out),
        .cam_y      (camera_y_out),
        .visible    (visible)
    );
`else
    assign visible = 1'b1;
`endif

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state            <= IDLE;
            npoly            <= '0;
            poly_idx         <= '0;
            base             <= '0;
            iss              <= '0;
            cap_idx          <= '0;
            wcnt             <= '0;
            vpipe            <= '0;
            tbl.tbl_addr_out <= '0;
            draw_start_out   <= 1'b0;
            frame_done_out   <= 1'b0;
            busy_out         <= 1'b0;
            skipped_out      <= '0;
            num_points_out   <= '0;
            camera_x_out     <= '0;
            camera_y_out     <= '0;
            for (int i = 0; i < MAX_NUM_VERTICES; i++) begin
                xs_out[i] <= '0;
                ys_out[i] <= '0;
            end
        end else begin
            draw_start_out <= 1'b0;
            frame_done_out <= 1'b0;
            // vpipe[k] marks a vertex read issued k+1 cycles ago.
            vpipe <= {vpipe[TBL_LATENCY-1:0], 1'b0};
            case (state)
                IDLE: begin
                    if (frame_start_in) begin
                        camera_x_out <= camera_x_in;
                        camera_y_out <= camera_y_in;
                        skipped_out  <= '0;
                        poly_idx     <= '0;
                        base         <= '0;
                        busy_out     <= 1'b1;
                        npoly <= (num_polygons_in > PW'(MAX_POLYGONS)) ?
                                 PW'(MAX_POLYGONS) : num_polygons_in;
                        if (num_polygons_in == '0) begin
                            state          <= FRAME_DONE;
                            frame_done_out <= 1'b1;
                        end else begin
                            state            <= FETCH_HDR;
                            tbl.tbl_addr_out <= '0;
                            wcnt             <= WCW'(TBL_LATENCY);
                        end
                    end
                end
                FETCH_HDR: begin
                    if (wcnt != '0) begin
                        wcnt <= wcnt - WCW'(1);
                    end else if (hdr_cnt < CW'(3) || hdr_cnt > CW'(MAX_NUM_VERTICES)) begin
                        skipped_out <= skipped_out + PW'(1);
                        state       <= NEXT;
                    end else begin
                        num_points_out   <= hdr_cnt;
                        tbl.tbl_addr_out <= base + AW'(1);
                        iss              <= CW'(1);
                        cap_idx          <= '0;
                        vpipe[0]         <= 1'b1;
                        state            <= FETCH_VERTS;
                    end
                end
                FETCH_VERTS: begin
                    if (iss != num_points_out) begin
                        tbl.tbl_addr_out <= tbl.tbl_addr_out + AW'(1);
                        iss              <= iss + CW'(1);
                        vpipe[0]         <= 1'b1;
                    end
                    if (vpipe[TBL_LATENCY]) begin
                        xs_out[cap_idx] <= tbl.tbl_x_in;
                        ys_out[cap_idx] <= tbl.tbl_y_in;
                        cap_idx         <= cap_idx + IW'(1);
                        if ({1'b0, cap_idx} == num_points_out - CW'(1))
                            state <= START;
                    end
                end
                START: begin
                    if (visible) begin
                        draw_start_out <= 1'b1;
                        state          <= WAIT_DONE;
                    end else begin
                        skipped_out <= skipped_out + PW'(1);
                        state       <= NEXT;
                    end
                end
                WAIT_DONE: begin
                    if (draw_done_in)
                        state <= NEXT;
                end
                NEXT: begin
                    poly_idx <= poly_idx + PW'(1);
                    base     <= base + STRIDE;
                    if (poly_idx + PW'(1) == npoly) begin
                        state          <= FRAME_DONE;
                        frame_done_out <= 1'b1;
                    end else begin
                        state            <= FETCH_HDR;
                        tbl.tbl_addr_out <= base + STRIDE;
                        wcnt             <= WCW'(TBL_LATENCY);
                    end
                end
                FRAME_DONE: begin
                    state    <= IDLE;
                    busy_out <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_polygon_sequencer.sv
// Directed bench for polygon_sequencer: frame vectors from a table plus
// hand-written sequences for zero-polygon frames, mid-pass reset and culling.
module tb_polygon_sequencer;
    localparam int NV  = 4;
    localparam int NP  = 16;
    localparam int LAT = 2;
    localparam int AW  = $clog2(NP * (NV + 1));
    localparam int NV_VEC = 8;

    typedef struct {
        int npoly;
        int c0, c1, c2;
        int cx, cy;
        int dly;
        int poke;
        int exp_starts;
        int exp_skip;
    } vec_t;

    logic clk_in = 1'b0;
    logic rst_in = 1'b0;
    logic frame_start_in = 1'b0;
    logic draw_done_in = 1'b0;
    logic [$clog2(NP):0] num_polygons_in = '0;
    logic signed [31:0]  camera_x_in = '0;
    logic signed [31:0]  camera_y_in = '0;
    logic                draw_start_out, busy_out, frame_done_out;
    logic signed [31:0]  xs_out [NV];
    logic signed [31:0]  ys_out [NV];
    logic [$clog2(NV):0] num_points_out;
    logic signed [31:0]  camera_x_out, camera_y_out;
    logic [$clog2(NP):0] skipped_out;

    polygon_sequencer_if #(.MAX_NUM_VERTICES(NV), .MAX_POLYGONS(NP)) tif ();

    polygon_sequencer #(
        .MAX_NUM_VERTICES(NV), .MAX_POLYGONS(NP), .TBL_LATENCY(LAT)
    ) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .frame_start_in  (frame_start_in),
        .num_polygons_in (num_polygons_in),
        .camera_x_in     (camera_x_in),
        .camera_y_in     (camera_y_in),
        .tbl             (tif),
        .draw_start_out  (draw_start_out),
        .xs_out          (xs_out),
        .ys_out          (ys_out),
        .num_points_out  (num_points_out),
        .camera_x_out    (camera_x_out),
        .camera_y_out    (camera_y_out),
        .draw_done_in    (draw_done_in),
        .busy_out        (busy_out),
        .frame_done_out  (frame_done_out),
        .skipped_out     (skipped_out)
    );

    always #5 clk_in = ~clk_in;

    // Table memory: data for an address appears LAT cycles after it is presented.
    logic signed [31:0] mem_x [NP*(NV+1)];
    logic signed [31:0] mem_y [NP*(NV+1)];
    logic [AW-1:0]      ap [LAT];
    always @(posedge clk_in) begin
        ap[0] <= tif.tbl_addr_out;
        for (int i = 1; i < LAT; i++) ap[i] <= ap[i-1];
    end
    assign tif.tbl_x_in = mem_x[ap[LAT-1]];
    assign tif.tbl_y_in = mem_y[ap[LAT-1]];

    int checks = 0;
    int errors = 0;
    logic signed [31:0] exp_x [NV];
    logic signed [31:0] exp_y [NV];
    int exp_np;
    vec_t vecs [NV_VEC];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NV; i++) begin
            exp_x[i] = 0;
            exp_y[i] = 0;
        end
        exp_np = 0;
    endtask

    // Square vertices (x0,y0),(x0+100,y0),(x0+100,y0+100),(x0,y0+100); junk above count bits.
    task automatic load_poly(input int p, input int cnt, input int x0, input int y0);
        mem_x[p*(NV+1)] = cnt + 32'h100;
        mem_y[p*(NV+1)] = 0;
        for (int i = 0; i < NV; i++) begin
            mem_x[p*(NV+1)+1+i] = x0 + ((i == 1 || i == 2) ? 100 : 0);
            mem_y[p*(NV+1)+1+i] = y0 + ((i >= 2) ? 100 : 0);
        end
    endtask

    task automatic load_all(input int c0, input int c1, input int c2);
        for (int p = 0; p < NP; p++)
            load_poly(p, (p == 0) ? c0 : (p == 1) ? c1 : (p == 2) ? c2 : 3,
                      100 + 10*p, 100 + 20*p);
    endtask

    task automatic check_outputs(input string tag, input int cx, input int cy);
        chk({tag, " num_points"}, num_points_out, exp_np);
        for (int i = 0; i < NV; i++) begin
            chk($sformatf("%s xs[%0d]", tag, i), xs_out[i], exp_x[i]);
            chk($sformatf("%s ys[%0d]", tag, i), ys_out[i], exp_y[i]);
        end
        chk({tag, " camera_x"}, camera_x_out, cx);
        chk({tag, " camera_y"}, camera_y_out, cy);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " busy"}, busy_out, 0);
        chk({tag, " draw_start"}, draw_start_out, 0);
        chk({tag, " frame_done"}, frame_done_out, 0);
        chk({tag, " skipped"}, skipped_out, 0);
        chk({tag, " tbl_addr"}, tif.tbl_addr_out, 0);
        chk({tag, " num_points"}, num_points_out, 0);
        chk({tag, " camera_x"}, camera_x_out, 0);
        chk({tag, " camera_y"}, camera_y_out, 0);
        for (int i = 0; i < NV; i++) begin
            chk($sformatf("%s xs[%0d]", tag, i), xs_out[i], 0);
            chk($sformatf("%s ys[%0d]", tag, i), ys_out[i], 0);
        end
    endtask

    task automatic run_frame(input vec_t v, input string name);
        int vlist[$];
        int n, c, p;
        int starts = 0, fdones = 0, dly = 0, poke = 0, post = 0;
        int fd_cyc = -1, dn_cyc = -1;
        bit fd = 1'b0;
        n = (v.npoly > NP) ? NP : v.npoly;
        for (int q = 0; q < n; q++) begin
            c = int'(mem_x[q*(NV+1)]) & 7;
            if (c >= 3 && c <= NV) vlist.push_back(q);
        end
        @(negedge clk_in);
        frame_start_in  = 1'b1;
        num_polygons_in = v.npoly[$clog2(NP):0];
        camera_x_in     = v.cx;
        camera_y_in     = v.cy;
        @(negedge clk_in);
        frame_start_in  = 1'b0;
        num_polygons_in = '0;
        camera_x_in     = -1;
        camera_y_in     = -1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            frame_start_in = 1'b0;
            draw_done_in   = 1'b0;
            if (poke != 0) begin
                frame_start_in  = 1'b1;
                num_polygons_in = 1;
                poke = 0;
            end
            if (dly > 0) begin
                dly--;
                if (dly == 0) begin
                    check_outputs({name, " stable"}, v.cx, v.cy);
                    draw_done_in = 1'b1;
                    dn_cyc = cyc;
                end
            end
            if (draw_start_out) begin
                if (starts < vlist.size()) begin
                    p = vlist[starts];
                    c = int'(mem_x[p*(NV+1)]) & 7;
                    exp_np = c;
                    for (int i = 0; i < c; i++) begin
                        exp_x[i] = mem_x[p*(NV+1)+1+i];
                        exp_y[i] = mem_y[p*(NV+1)+1+i];
                    end
                end
                check_outputs($sformatf("%s start%0d", name, starts), v.cx, v.cy);
                starts++;
                dly = v.dly;
                if (v.poke != 0 && starts == 1) poke = 1;
            end
            if (frame_done_out) begin
                fdones++;
                fd = 1'b1;
                fd_cyc = cyc;
            end
            if (fd) post++;
            if (post > 6) break;
            @(negedge clk_in);
        end
        draw_done_in   = 1'b0;
        frame_start_in = 1'b0;
        chk({name, " frame_done seen"}, fd, 1);
        chk({name, " draw_starts"}, starts, v.exp_starts);
        chk({name, " skipped"}, skipped_out, v.exp_skip);
        chk({name, " frame_done pulses"}, fdones, 1);
        chk({name, " idle at end"}, busy_out, 0);
        if (v.exp_starts > 0)
            chk({name, " frame_done after draw_done"}, (fd_cyc > dn_cyc) ? 1 : 0, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        vec_t cv;
        bit stray;
        //             npoly c0 c1 c2  cx   cy  dly poke starts skip
        vecs[0] = '{1,   4, 4, 4, 640, 360, 3, 0, 1,  0};
        vecs[1] = '{3,   4, 2, 3, 700, 400, 2, 0, 2,  1};
        vecs[2] = '{3,   0, 5, 7, 640, 360, 2, 0, 0,  3};
        vecs[3] = '{2,   4, 3, 4, 700, 400, 1, 0, 2,  0};
        vecs[4] = '{0,   4, 4, 4, 640, 360, 1, 0, 0,  0};
        vecs[5] = '{20,  4, 4, 4, 640, 360, 1, 0, 16, 0};
        vecs[6] = '{16,  2, 4, 6, 700, 400, 2, 0, 14, 2};
        vecs[7] = '{1,   4, 4, 4, 640, 360, 6, 1, 1,  0};

        model_reset();
        load_all(4, 4, 4);
        rst_in = 1'b0;
        repeat (3) @(negedge clk_in);
        check_zero("in_reset");
        rst_in = 1'b1;
        @(negedge clk_in);
        check_zero("after_release");

        // Empty frame: frame_done the cycle right after the accepting edge.
        frame_start_in  = 1'b1;
        num_polygons_in = '0;
        @(negedge clk_in);
        frame_start_in = 1'b0;
        chk("empty frame_done next cycle", frame_done_out, 1);
        chk("empty no draw_start", draw_start_out, 0);
        @(negedge clk_in);
        chk("empty frame_done single", frame_done_out, 0);
        chk("empty back to idle", busy_out, 0);

        for (int k = 0; k < NV_VEC; k++) begin
            load_all(vecs[k].c0, vecs[k].c1, vecs[k].c2);
            run_frame(vecs[k], $sformatf("vec%0d", k));
        end

        // Reset while vertex reads are still in flight.
        load_all(4, 4, 4);
        @(negedge clk_in);
        frame_start_in  = 1'b1;
        num_polygons_in = 3;
        camera_x_in     = 700;
        camera_y_in     = 400;
        @(negedge clk_in);
        frame_start_in = 1'b0;
        repeat (5) @(negedge clk_in);
        chk("midreset busy before", busy_out, 1);
        rst_in = 1'b0;
        @(negedge clk_in);
        check_zero("midreset");
        rst_in = 1'b1;
        model_reset();
        stray = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk_in);
            if (busy_out || draw_start_out || frame_done_out) stray = 1'b1;
        end
        chk("midreset stays idle", stray, 0);
        run_frame(vecs[0], "post_reset");

`ifdef POLYGON_SEQ_CULL_EN
        load_all(4, 4, 4);
        load_poly(0, 4, 5000, 100);
        cv = '{1, 4, 4, 4, 640, 360, 2, 0, 0, 1};
        run_frame(cv, "cull_far");
        load_poly(0, 4, 100, 100);
        cv = '{1, 4, 4, 4, 640, 360, 2, 0, 1, 0};
        run_frame(cv, "cull_near");
`else
        cv = vecs[0];
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/polygon_sequencer.md
POLYGON_SEQUENCER -- requirements
Module: polygon_sequencer

Interface
REQ-001 Parameter MAX_NUM_VERTICES, default 4: maximum vertices per polygon.
REQ-002 Parameter MAX_POLYGONS, default 16: polygon table capacity.
REQ-003 Parameter TBL_LATENCY, default 2: table read latency in cycles.
REQ-004 clk_in  input  1  sole clock; all logic SHALL be on the rising edge.
REQ-005 rst_in  input  1  reset; synchronous and active-low.
REQ-006 frame_start_in  input  1  one-cycle pulse that begins a pass over the table.
REQ-007 num_polygons_in  input  $clog2(MAX_POLYGONS)+1  polygons in the pass; sampled at accept.
REQ-008 camera_x_in, camera_y_in  input  32 signed  camera position; sampled at accept.
REQ-009 tbl_addr_out  output  $clog2(MAX_POLYGONS*(MAX_NUM_VERTICES+1))  table read address.
REQ-010 tbl_x_in, tbl_y_in  input  32 signed  table data, valid TBL_LATENCY cycles after the address.
REQ-011 draw_start_out  output  1  one-cycle start pulse to the polygon rasteriser.
REQ-012 xs_out, ys_out  output  [MAX_NUM_VERTICES] x 32 signed  vertex arrays, in table order.
REQ-013 num_points_out  output  $clog2(MAX_NUM_VERTICES)+1  vertex count of the current polygon.
REQ-014 camera_x_out, camera_y_out  output  32 signed  latched camera position.
REQ-015 draw_done_in  input  1  rasteriser completion pulse.
REQ-016 busy_out  output  1  high in every state except IDLE.
REQ-017 frame_done_out  output  1  one-cycle pulse at the end of a pass.
REQ-018 skipped_out  output  $clog2(MAX_POLYGONS)+1  polygons skipped in the last pass.

Function
REQ-019 Table layout: polygon p occupies a block of MAX_NUM_VERTICES+1 entries starting at p*(MAX_NUM_VERTICES+1).
- Entry 0: count in tbl_x_in[$clog2(MAX_NUM_VERTICES):0].
- Entries 1..count: vertex (x,y).
REQ-020 FSM states: IDLE, FETCH_HDR, FETCH_VERTS, START, WAIT_DONE, NEXT, FRAME_DONE.
REQ-021 IDLE: frame_start_in accepted.
- Latch inputs and clear skipped_out.
- Go to FRAME_DONE if num_polygons_in==0, else FETCH_HDR.
REQ-022 FETCH_HDR: issue the entry-0 address, wait TBL_LATENCY cycles.
- Count <3 or >MAX_NUM_VERTICES: increment skipped_out, go to NEXT.
- Otherwise go to FETCH_VERTS.
REQ-023 FETCH_VERTS: issue one address per cycle, back-to-back.
- Capture vertex i into xs_out[i]/ys_out[i] exactly TBL_LATENCY cycles after its address.
- Go to START after the last capture.
REQ-024 START: assert draw_start_out for exactly one cycle, go to WAIT_DONE.
REQ-025 xs_out, ys_out, num_points_out and camera_*_out SHALL be stable from START until draw_done_in is seen.
REQ-026 WAIT_DONE: on draw_done_in go to NEXT.
- draw_done_in in any other state is ignored.
REQ-027 NEXT: increment the polygon index.
- Index == latched count: go to FRAME_DONE.
- Otherwise go to FETCH_HDR.
REQ-028 FRAME_DONE: assert frame_done_out one cycle, go to IDLE.
REQ-029 frame_start_in while busy_out=1 SHALL be ignored, not queued.
REQ-030 Vertex slots at index >= count SHALL retain their previous values.
REQ-031 Latched polygon count above MAX_POLYGONS SHALL be clamped to MAX_POLYGONS.

Reset
REQ-032 rst_in=0 at a rising edge, in any state including mid-pass, SHALL:
- Enter IDLE.
- Zero all outputs: draw_start_out, frame_done_out, busy_out, skipped_out, tbl_addr_out, xs_out, ys_out, num_points_out, camera_*_out.
- Discard in-flight table reads.

Configuration
REQ-033 With POLYGON_SEQ_CULL_EN defined, START SHALL first compare the vertex bounding box with the viewport camera_x-640..camera_x+639 and camera_y-360..camera_y+359 (inclusive).
- Bounding box entirely outside: skip draw_start_out, increment skipped_out, go to NEXT.
REQ-034 Without POLYGON_SEQ_CULL_EN, no culling logic SHALL be synthesised and all valid polygons are started.

Structure
REQ-035 A shared package SHALL hold:
- The FSM state enum.
- Screen half-width 640 and half-height 360.
- The table stride function.
REQ-036 One sub-module, bbox_cull, SHALL compute min/max and the overlap test, and is instantiated only under POLYGON_SEQ_CULL_EN.

Verification
REQ-037 Reset mid-FETCH_VERTS -> next cycle busy_out=0, all outputs 0; a fresh frame_start_in then runs correctly.
REQ-038 num_polygons_in=0, frame_start_in pulse -> frame_done_out pulses the next cycle; no draw_start_out.
REQ-039 Single square (100,100),(200,100),(200,200),(100,200), TBL_LATENCY=2:
- One draw_start_out with those arrays and num_points_out=4.
- frame_done_out follows draw_done_in.
REQ-040 Three polygons, middle count=2 -> two draw_start_out pulses, skipped_out=1.
REQ-041 frame_start_in pulsed during WAIT_DONE -> ignored; exactly one frame_done_out.
REQ-042 Cull enabled, camera (640,360), square at x 5000..5100 -> no draw_start_out, skipped_out=1; the same square at x 100..200 -> started.
